// File: rtl/wb_write_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue_pkg
// Description : Shared constants and types for the register-file write-back
//               queue (register geometry, zero register, queue entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
package wb_write_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One pending register-file write: destination register and its value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Generic in-order FIFO with asynchronous active-high reset.
//               Exposes per-slot occupancy and the top TAG_W bits of every
//               slot so a scoreboard can be built over the queued entries.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REG_ADDR_W + REG_DATA_W,
  parameter int TAG_W = REG_ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][TAG_W-1:0]  entry_tag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are meaningless until marked valid, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // A slot is occupied when its distance from the read pointer is below count.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(i) - rd_ptr;
      assign entry_valid[i] = ({1'b0, offset} < cnt);
      assign entry_tag[i]   = mem[i][WIDTH-1 -: TAG_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : Write side of the 2R/1W register file. Arbitrates ALU and load
//               write-backs (loads win), drops writes to R0, queues requests in
//               order and issues at most one RW/PW/LE write per clock. Exports a
//               per-register busy scoreboard derived from queue contents.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     hold,
  output logic [ADDR_W-1:0]        RW,
  output logic [DATA_W-1:0]        PW,
  output logic                     LE,
  output logic [NUM_REGS-1:0]      busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic                          mem_fire;
  logic                          alu_fire;
  logic                          push;
  entry_t                        push_entry;
  logic [ENTRY_W-1:0]            head_bits;
  entry_t                        head_entry;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]  entry_tag;

  // Readiness looks only at current fullness, never at a same-cycle pop.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;

  // Pick the accepted request; R0 targets complete the handshake but are dropped.
  always_comb begin
    push_entry = '{rd: alu_rd, data: alu_data};
    push       = 1'b0;
    if (mem_fire) begin
      push_entry = '{rd: mem_rd, data: mem_data};
      push       = (mem_rd != ADDR_W'(REG_ZERO));
    end else if (alu_fire) begin
      push       = (alu_rd != ADDR_W'(REG_ZERO));
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .TAG_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_entry),
    .pop         (LE),
    .head        (head_bits),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_tag   (entry_tag)
  );

  assign head_entry = head_bits;

  // Issue straight from the head; outputs are forced to zero when idle.
  always_comb begin
    LE = !empty && !hold;
    RW = '0;
    PW = '0;
    if (LE) begin
      RW = head_entry.rd;
      PW = head_entry.data;
    end
  end

  // Scoreboard: a register is busy while any occupied slot targets it (never R0).
  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (entry_valid[e] && (entry_tag[e] == ADDR_W'(r))) busy[r] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Directed bench for wb_write_queue with a small register-file
//               model that captures RW/PW on LE and logs issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, hold;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, LE, full, empty;
  logic [4:0]  RW;
  logic [31:0] PW;
  logic [31:0] busy;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  wb_entry_t   issued [$];
  wb_entry_t   exp_order [7];

  wb_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .hold      (hold),
    .RW        (RW),
    .PW        (PW),
    .LE        (LE),
    .busy      (busy),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Register-file model: R0 is hard-wired zero; every issued write is logged.
  always @(posedge clk) begin
    if (LE) begin
      if (RW != 5'd0) rf[RW] <= PW;
      issued.push_back('{rd: RW, data: PW});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1; hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    exp_order[0] = '{rd: 5'd9,  data: 32'h901};
    exp_order[1] = '{rd: 5'd7,  data: 32'h702};
    exp_order[2] = '{rd: 5'd9,  data: 32'h903};
    exp_order[3] = '{rd: 5'd2,  data: 32'h204};
    exp_order[4] = '{rd: 5'd11, data: 32'hB05};
    exp_order[5] = '{rd: 5'd12, data: 32'hC06};
    exp_order[6] = '{rd: 5'd13, data: 32'hD07};

    // ---- reset state
    #2;
    chk("rst_LE", LE, 0);       chk("rst_count", count, 0);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);   chk("rst_RW", RW, 0);
    chk("rst_PW", PW, 0);       chk("rst_mem_ready", mem_ready, 1);
    tick(); reset = 1'b0; tick();

    // ---- single write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("sw_alu_ready", alu_ready, 1); chk("sw_LE_pre", LE, 0); chk("sw_busy_pre", busy, 0);
    tick(); alu_valid = 1'b0;
    #1;
    chk("sw_LE", LE, 1); chk("sw_RW", RW, 5); chk("sw_PW", PW, 32'hDEADBEEF);
    chk("sw_busy", busy, 32'h20); chk("sw_count", count, 1);
    tick();
    chk("sw_LE_post", LE, 0); chk("sw_busy_post", busy, 0);
    chk("sw_count_post", count, 0); chk("sw_R5", rf[5], 32'hDEADBEEF);

    // ---- priority: load beats ALU
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    #1;
    chk("pr_alu_ready", alu_ready, 0); chk("pr_mem_ready", mem_ready, 1);
    tick(); mem_valid = 1'b0;
    #1;
    chk("pr_alu_ready2", alu_ready, 1); chk("pr_RW4", RW, 4); chk("pr_PW44", PW, 32'h44);
    tick(); alu_valid = 1'b0;
    #1;
    chk("pr_RW3", RW, 3); chk("pr_R4", rf[4], 32'h44); chk("pr_R3_pre", rf[3], 0);
    tick();
    chk("pr_R3", rf[3], 32'h33); chk("pr_empty", empty, 1);

    // ---- zero register filter
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
    #1;
    chk("z_mem_ready", mem_ready, 1);
    tick(); mem_valid = 1'b0;
    #1;
    chk("z_count", count, 0); chk("z_LE", LE, 0);
    tick();
    chk("z_LE2", LE, 0); chk("z_R0", rf[0], 0);

    // ---- full / backpressure
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'h100 + i;
      tick();
    end
    alu_rd = 5'd6; alu_data = 32'h66;
    #1;
    chk("f_full", full, 1); chk("f_alu_ready", alu_ready, 0); chk("f_mem_ready", mem_ready, 0);
    chk("f_count", count, 4); chk("f_LE_hold", LE, 0); chk("f_busy", busy, 32'h1E);
    tick();
    chk("f_count_wait", count, 4);
    hold = 1'b0;
    #1;
    chk("f_RW1", RW, 1); chk("f_ready_still0", alu_ready, 0);
    tick();
    chk("f_RW2", RW, 2); chk("f_ready_open", alu_ready, 1);
    tick(); alu_valid = 1'b0;
    #1;
    chk("f_RW3", RW, 3);
    tick();
    chk("f_RW4", RW, 4);
    tick();
    chk("f_RW6", RW, 6); chk("f_PW66", PW, 32'h66);
    tick();
    chk("f_empty", empty, 1); chk("f_R6", rf[6], 32'h66); chk("f_R4", rf[4], 32'h104);

    // ---- wrap-around and scoreboard
    issued.delete();
    hold = 1'b1; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h901;
    #1; chk("w_alu_ready", alu_ready, 1);
    tick();
    alu_rd = 5'd7; alu_data = 32'h702;
    tick();
    alu_rd = 5'd9; alu_data = 32'h903;
    #1; chk("w_busy97", busy, 32'h280);
    tick();
    hold = 1'b0; alu_rd = 5'd2; alu_data = 32'h204;
    #1; chk("w_RW9a", RW, 9); chk("w_count3", count, 3);
    tick();
    alu_rd = 5'd11; alu_data = 32'hB05;
    #1; chk("w_RW7", RW, 7); chk("w_busy9_a", busy[9], 1);
    tick();
    hold = 1'b1; alu_rd = 5'd12; alu_data = 32'hC06;
    #1; chk("w_LE_hold", LE, 0);
    tick();
    hold = 1'b0; alu_rd = 5'd13; alu_data = 32'hD07;
    #1; chk("w_full", full, 1); chk("w_ready0", alu_ready, 0);
    chk("w_RW9b", RW, 9); chk("w_busy9_b", busy[9], 1);
    tick();
    #1; chk("w_ready1", alu_ready, 1); chk("w_busy9_clr", busy[9], 0); chk("w_RW2", RW, 2);
    tick(); alu_valid = 1'b0;
    #1; chk("w_RW11", RW, 11);
    tick(); chk("w_RW12", RW, 12);
    tick(); chk("w_RW13", RW, 13); chk("w_count1", count, 1);
    tick(); chk("w_empty", empty, 1);
    chk("w_issued_n", issued.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < issued.size()) chk($sformatf("w_order%0d", k), issued[k], exp_order[k]);
    end

    // ---- asynchronous reset mid-stream
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hA0 + i;
      tick();
    end
    alu_valid = 1'b0;
    #1; chk("r_count3", count, 3);
    hold = 1'b0;
    #1; chk("r_LE_live", LE, 1); chk("r_RW20", RW, 20);
    reset = 1'b1;
    #1;
    chk("r_LE", LE, 0); chk("r_count", count, 0); chk("r_busy", busy, 0);
    chk("r_empty", empty, 1); chk("r_RW", RW, 0);
    tick(); reset = 1'b0; issued.delete();
    tick(); tick();
    chk("r_LE_after", LE, 0); chk("r_no_issue", issued.size(), 0); chk("r_R20", rf[20], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
